// File: rtl/uart_tx_ctrl_pkg.sv
// rtl/uart_tx_ctrl_pkg.sv - shared constants, FSM state encoding and helpers for the UART transmit sequencer
package uart_tx_ctrl_pkg;

    localparam int   DATA_WIDTH = 8;
    localparam logic IDLE_LEVEL = 1'b1;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } tx_state_t;

    // Tick counter width: enough bits for TICKS_PER_BIT-1, never narrower than one bit.
    function automatic int tick_width(input int ticks);
        return (ticks > 1) ? $clog2(ticks) : 1;
    endfunction

endpackage

// File: rtl/uart_tx_ctrl_parity_gen.sv
// rtl/uart_tx_ctrl_parity_gen.sv - parity bit generator (even or odd) for one data byte
module parity_gen
    import uart_tx_ctrl_pkg::*;
(
    input  logic                  even_odd,
    input  logic [DATA_WIDTH-1:0] tx_data_in,
    output logic                  parity_bit
);

    // Even parity makes the total count of ones even; odd parity makes it odd.
    always_comb begin
        parity_bit = even_odd ? (^tx_data_in) : (~^tx_data_in);
    end

endmodule

// File: rtl/uart_tx_ctrl.sv
// rtl/uart_tx_ctrl.sv - UART transmit sequencer: start, data LSB-first, optional parity, stop bit(s)
module uart_tx_ctrl
    import uart_tx_ctrl_pkg::*;
#(
    parameter int TICKS_PER_BIT = 16,
    parameter int STOP_BITS     = 1
)(
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  baud_tick,
    input  logic [DATA_WIDTH-1:0] tx_data_in,
    input  logic                  tx_valid,
    output logic                  tx_ready,
    input  logic                  parity_en,
    input  logic                  even_odd,
    output logic                  tx_serial,
    output logic                  tx_busy,
    output logic                  tx_done
);

    localparam int            TW       = tick_width(TICKS_PER_BIT);
    localparam logic [TW-1:0] TICK_MAX = TW'(TICKS_PER_BIT - 1);

    tx_state_t             state;
    tx_state_t             next_state;
    logic [TW-1:0]         tick_cnt;
    logic [2:0]            bit_idx;
    logic                  stop_cnt;
    logic [DATA_WIDTH-1:0] data_q;
    logic                  par_en_q;
    logic                  even_odd_q;
    logic                  done_q;
    logic                  parity_bit;
    logic                  accept;
    logic                  bit_end;
    logic                  last_stop;

    assign accept    = tx_valid && (state == ST_IDLE);
    assign bit_end   = baud_tick && (tick_cnt == TICK_MAX);
    assign last_stop = (STOP_BITS < 2) ? 1'b1 : stop_cnt;

    // Parity follows the latched byte and mode, so it cannot change mid-frame.
    parity_gen u_parity_gen (
        .even_odd   (even_odd_q),
        .tx_data_in (data_q),
        .parity_bit (parity_bit)
    );

    // State register; reset drops any frame in flight and returns to IDLE.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state: each serial bit ends on the baud tick that wraps the tick counter.
    always_comb begin
        next_state = state;
        case (state)
            ST_IDLE: begin
                if (accept) next_state = ST_START;
            end
            ST_START: begin
                if (bit_end) next_state = ST_DATA;
            end
            ST_DATA: begin
                if (bit_end && (bit_idx == 3'd7)) begin
                    next_state = par_en_q ? ST_PARITY : ST_STOP;
                end
            end
            ST_PARITY: begin
                if (bit_end) next_state = ST_STOP;
            end
            ST_STOP: begin
                if (bit_end && last_stop) next_state = ST_IDLE;
            end
            default: next_state = ST_IDLE;
        endcase
    end

    // Outputs decoded from state so the line goes high as soon as reset asserts.
    always_comb begin
        tx_serial = IDLE_LEVEL;
        case (state)
            ST_START:  tx_serial = 1'b0;
            ST_DATA:   tx_serial = data_q[bit_idx];
            ST_PARITY: tx_serial = parity_bit;
            ST_STOP:   tx_serial = 1'b1;
            default:   tx_serial = IDLE_LEVEL;
        endcase
        tx_ready = (state == ST_IDLE);
        tx_busy  = (state != ST_IDLE);
        tx_done  = done_q;
    end

    // Tick counter: cleared on accept (a tick on that cycle is not counted), wraps at end of bit.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tick_cnt <= '0;
        end else if (accept) begin
            tick_cnt <= '0;
        end else if ((state != ST_IDLE) && baud_tick) begin
            tick_cnt <= bit_end ? '0 : tick_cnt + 1'b1;
        end
    end

    // Data bit index and stop-bit counter; the index holds at 7 rather than wrapping.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bit_idx  <= 3'd0;
            stop_cnt <= 1'b0;
        end else if (accept) begin
            bit_idx  <= 3'd0;
            stop_cnt <= 1'b0;
        end else begin
            if ((state == ST_DATA) && bit_end && (bit_idx != 3'd7)) begin
                bit_idx <= bit_idx + 3'd1;
            end
            if ((state == ST_STOP) && bit_end) begin
                stop_cnt <= ~stop_cnt;
            end
        end
    end

    // Frame parameters captured on accept; later input changes are ignored.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            data_q     <= '0;
            par_en_q   <= 1'b0;
            even_odd_q <= 1'b0;
        end else if (accept) begin
            data_q     <= tx_data_in;
            par_en_q   <= parity_en;
            even_odd_q <= even_odd;
        end
    end

    // Done pulse lands in the first IDLE cycle, alongside tx_ready.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            done_q <= 1'b0;
        end else begin
            done_q <= (state == ST_STOP) && bit_end && last_stop;
        end
    end

endmodule
